// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall merge, exception/eret flush sequencing and stall tracking
// Ports:
//   clk, rst                           clock, asynchronous active-high reset
//   stallreq_id/ex/mem                 per-stage stall requests
//   excepttype, cp0_epc                exception code from MEM (0 = none), current EPC
//   stall[5:0]                         hold vector: PC, IF/ID, ID/EX, EX/MEM, MEM/WB, WB
//   flush, new_pc                      one-cycle flush with its redirect address
//   stall_timeout, stall_cycles        sticky watchdog flag, total stalled-cycle count
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_0020,
  parameter logic [31:0] ERET_CODE   = 32'h0000_000e,
  parameter logic [15:0] STALL_LIMIT = 16'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout,
  output logic [31:0] stall_cycles
);
  typedef enum logic {RUN, FLUSH} state_t;
  state_t state, state_nxt;
  logic [15:0] cnt;
  logic        exc;
  logic        stalled;
  assign exc     = state == RUN && excepttype != 32'h0;
  assign stalled = stall != 6'b000000;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= RUN;
    else     state <= state_nxt;
  always_comb state_nxt = exc ? FLUSH : RUN;
  // An exception (or the flush cycle itself) overrides every stall request.
  always_comb begin
    flush = state == FLUSH;
    stall = (state == FLUSH || exc) ? 6'b000000 :
            stallreq_mem            ? 6'b011111 :
            stallreq_ex             ? 6'b001111 :
            stallreq_id             ? 6'b000111 : 6'b000000;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) new_pc <= 32'h0;
    else if (exc) new_pc <= excepttype == ERET_CODE ? cp0_epc : EXC_VECTOR;
  // Flag trips on the edge that brings cnt up to the limit.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt           <= 16'h0;
      stall_timeout <= 1'b0;
      stall_cycles  <= 32'h0;
    end else begin
      cnt           <= !stalled ? 16'h0 : cnt == STALL_LIMIT ? cnt : cnt + 16'h1;
      stall_timeout <= stall_timeout | (stalled && cnt == STALL_LIMIT - 16'h1);
      stall_cycles  <= stall_cycles + {31'h0, stalled};
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl with STALL_LIMIT=4
module tb_pipe_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id, stallreq_ex, stallreq_mem;
  logic [31:0] excepttype, cp0_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
  logic [31:0] stall_cycles;
  int checks = 0;
  int errors = 0;
  pipe_ctrl #(.STALL_LIMIT(16'd4)) dut (
    .clk(clk), .rst(rst),
    .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .excepttype(excepttype), .cp0_epc(cp0_epc),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .stall_timeout(stall_timeout), .stall_cycles(stall_cycles)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    stallreq_id = 1'b0; stallreq_ex = 1'b0; stallreq_mem = 1'b0;
    excepttype = 32'h0; cp0_epc = 32'h0;
    #12;
    chk("rst_stall", {26'h0, stall}, 32'h0);
    chk("rst_flush", {31'h0, flush}, 32'h0);
    chk("rst_new_pc", new_pc, 32'h0);
    chk("rst_timeout", {31'h0, stall_timeout}, 32'h0);
    chk("rst_cycles", stall_cycles, 32'h0);
    rst = 1'b0;
    tick;
    stallreq_id = 1'b1; #1;
    chk("prio_id", {26'h0, stall}, 32'b000111);
    tick;
    stallreq_ex = 1'b1; #1;
    chk("prio_ex", {26'h0, stall}, 32'b001111);
    tick;
    stallreq_mem = 1'b1; #1;
    chk("prio_mem", {26'h0, stall}, 32'b011111);
    tick;
    stallreq_id = 1'b0; stallreq_ex = 1'b0; stallreq_mem = 1'b0; #1;
    chk("prio_none", {26'h0, stall}, 32'h0);
    tick;
    chk("prio_cycles", stall_cycles, 32'd3);
    chk("wd_3cyc_no_timeout", {31'h0, stall_timeout}, 32'h0);
    stallreq_ex = 1'b1;
    tick; tick; tick;
    chk("wd_before_4th", {31'h0, stall_timeout}, 32'h0);
    tick;
    chk("wd_after_4th", {31'h0, stall_timeout}, 32'h1);
    stallreq_ex = 1'b0;
    tick;
    chk("wd_sticky", {31'h0, stall_timeout}, 32'h1);
    chk("wd_cycles", stall_cycles, 32'd7);
    excepttype = 32'h1; #1;
    chk("exc_no_flush_yet", {31'h0, flush}, 32'h0);
    tick;
    excepttype = 32'h0; #1;
    chk("exc_flush", {31'h0, flush}, 32'h1);
    chk("exc_new_pc", new_pc, 32'h20);
    chk("exc_stall_in_flush", {26'h0, stall}, 32'h0);
    tick;
    chk("exc_flush_drop", {31'h0, flush}, 32'h0);
    chk("exc_new_pc_hold", new_pc, 32'h20);
    cp0_epc = 32'h0000_1234; excepttype = 32'he;
    tick;
    excepttype = 32'h0;
    chk("eret_flush", {31'h0, flush}, 32'h1);
    chk("eret_new_pc", new_pc, 32'h1234);
    tick;
    chk("eret_flush_drop", {31'h0, flush}, 32'h0);
    excepttype = 32'h1; stallreq_mem = 1'b1; #1;
    chk("coll_stall_zero", {26'h0, stall}, 32'h0);
    tick;
    excepttype = 32'h0; #1;
    chk("coll_flush", {31'h0, flush}, 32'h1);
    chk("coll_new_pc", new_pc, 32'h20);
    chk("coll_stall_flush", {26'h0, stall}, 32'h0);
    tick;
    chk("coll_stall_resume", {26'h0, stall}, 32'b011111);
    chk("coll_cycles_before", stall_cycles, 32'd7);
    tick;
    stallreq_mem = 1'b0;
    chk("coll_cycles_after", stall_cycles, 32'd8);
    cp0_epc = 32'h0000_4444; excepttype = 32'h1;
    tick;
    chk("held_flush", {31'h0, flush}, 32'h1);
    tick;
    chk("held_single_flush", {31'h0, flush}, 32'h0);
    chk("held_new_pc", new_pc, 32'h20);
    excepttype = 32'he;
    tick;
    excepttype = 32'h0;
    chk("b2b_flush", {31'h0, flush}, 32'h1);
    chk("b2b_new_pc", new_pc, 32'h4444);
    tick;
    chk("b2b_flush_drop", {31'h0, flush}, 32'h0);
    stallreq_id = 1'b1;
    tick; tick;
    stallreq_id = 1'b0;
    chk("ar_cycles_10", stall_cycles, 32'd10);
    excepttype = 32'h1;
    tick;
    excepttype = 32'h0;
    chk("ar_flush_before", {31'h0, flush}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("ar_flush", {31'h0, flush}, 32'h0);
    chk("ar_new_pc", new_pc, 32'h0);
    chk("ar_cycles", stall_cycles, 32'h0);
    chk("ar_timeout", {31'h0, stall_timeout}, 32'h0);
    chk("ar_stall", {26'h0, stall}, 32'h0);
    #3 rst = 1'b0;
    tick;
    chk("ar_no_redirect", {31'h0, flush}, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
